// File: rtl/me_array_sequencer_if.sv
// Control/address bus between me_array_sequencer (master) and the frame buffer / PE chain (slave).
// The best-vector signals exist only when ME_BEST_MV_EN is defined.
interface me_array_sequencer_if #(
  parameter int BLK = 4,
`ifdef ME_BEST_MV_EN
  parameter int DW  = 16,
`endif
  parameter int NV  = 4
);
  localparam int RAW = (BLK * BLK > 1) ? $clog2(BLK * BLK) : 1;
  localparam int SAW = $clog2(2 * BLK * (NV + BLK - 1));
  localparam int DYW = (NV > 1) ? $clog2(NV) : 1;
`ifdef ME_BEST_MV_EN
  localparam int DXW = (BLK > 1) ? $clog2(BLK) : 1;
`endif

  logic           start;
  logic           busy;
  logic           done;
  logic [RAW-1:0] r_addr;
  logic [SAW-1:0] s1_addr;
  logic [SAW-1:0] s2_addr;
  logic [BLK-1:0] s1s2_mux;
  logic [BLK-1:0] new_dist;
  logic [BLK-1:0] acc_capture;
  logic [DYW-1:0] cand_dy;
`ifdef ME_BEST_MV_EN
  logic [BLK*DW-1:0] accumulate_bus;
  logic [DXW-1:0]    best_dx;
  logic [DYW-1:0]    best_dy;
  logic [DW-1:0]     best_sad;
`endif

  modport master (
`ifdef ME_BEST_MV_EN
    input  accumulate_bus,
    output best_dx, best_dy, best_sad,
`endif
    input  start,
    output busy, done, r_addr, s1_addr, s2_addr, s1s2_mux, new_dist, acc_capture, cand_dy
  );

  modport slave (
`ifdef ME_BEST_MV_EN
    output accumulate_bus,
    input  best_dx, best_dy, best_sad,
`endif
    output start,
    input  busy, done, r_addr, s1_addr, s2_addr, s1s2_mux, new_dist, acc_capture, cand_dy
  );
endinterface

// File: rtl/me_array_sequencer.sv
// Sequencer for a 1-D motion-estimation array of BLK PEs: per search row v it issues reference/search
// addresses, per-PE s1/s2 select and restart controls, and SAD capture strobes. Best-vector tracking: ME_BEST_MV_EN.
module me_array_sequencer #(
  parameter int BLK    = 4,
  parameter int NV     = 4,
`ifdef ME_BEST_MV_EN
  parameter int DW     = 16,
`endif
  parameter int PE_LAT = 1
) (
  input logic                  clock,
  input logic                  reset,
  me_array_sequencer_if.master bus
);
  localparam int SW   = 2 * BLK;
  localparam int NPIX = BLK * BLK;
  localparam int L    = NPIX + BLK - 1 + PE_LAT;
  localparam int TW   = (L > 1) ? $clog2(L) : 1;
  localparam int RAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SAW  = $clog2(SW * (NV + BLK - 1));
  localparam int DYW  = (NV > 1) ? $clog2(NV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DYW-1:0] v_q, v_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [RAW-1:0] r_addr_q, r_addr_d;
  logic [SAW-1:0] s1_addr_q, s1_addr_d;
  logic [SAW-1:0] s2_addr_q, s2_addr_d;
  logic [BLK-1:0] mux_q, mux_d;
  logic [BLK-1:0] new_dist_q, new_dist_d;
  logic [BLK-1:0] acc_capture_q, acc_capture_d;
  logic [DYW-1:0] cand_dy_q, cand_dy_d;

  // Pass/row sequencing: RUN covers t=0..BLK*BLK-1, DRAIN finishes the pass up to t=L-1.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          t_d     = '0;
          v_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        t_d = t_q + TW'(1);
        if (t_q == TW'(NPIX - 1)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (t_q == TW'(L - 1)) begin
          t_d = '0;
          if (v_q == DYW'(NV - 1)) begin
            state_d = S_IDLE;
            v_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            v_d     = v_q + DYW'(1);
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Output values for the (state, t, v) being entered, so the registers hold them during cycle t.
  always_comb begin
    int ti;
    int vi;
    int row;
    int col;
    ti            = int'(t_d);
    vi            = int'(v_d);
    row           = ti / BLK;
    col           = ti % BLK;
    busy_d        = (state_d != S_IDLE);
    r_addr_d      = '0;
    s1_addr_d     = '0;
    s2_addr_d     = '0;
    mux_d         = '0;
    new_dist_d    = '0;
    acc_capture_d = '0;
    cand_dy_d     = '0;
    if (busy_d) begin
      cand_dy_d = v_d;
      if (state_d == S_RUN) begin
        r_addr_d  = RAW'(ti);
        s1_addr_d = SAW'((vi + row) * SW + col);
      end else begin
        r_addr_d  = '0;
        s1_addr_d = '0;
      end
      if ((row >= 1) && (row <= BLK)) begin
        s2_addr_d = SAW'((vi + row - 1) * SW + col + BLK);
      end else begin
        s2_addr_d = '0;
      end
      // PE k sees the reference stream k cycles late; it stays on s1 until its row column wraps.
      for (int k = 0; k < BLK; k++) begin
        if (ti >= k) begin
          mux_d[k] = ((((ti - k) % BLK) + k) < BLK);
        end else begin
          mux_d[k] = 1'b1;
        end
        new_dist_d[k]    = (state_d == S_RUN) && (ti == k);
        acc_capture_d[k] = (ti == NPIX - 1 + k + PE_LAT);
      end
    end else begin
      cand_dy_d = '0;
    end
  end

`ifdef ME_BEST_MV_EN
  localparam int DXW = (BLK > 1) ? $clog2(BLK) : 1;

  logic [DXW-1:0] best_dx_q, best_dx_d;
  logic [DYW-1:0] best_dy_q, best_dy_d;
  logic [DW-1:0]  best_sad_q, best_sad_d;
  logic [DXW-1:0] sel_k_s;
  logic [DW-1:0]  sel_sad_s;

  // Capture strobes are one-hot in (v, k) order; strict less-than keeps the earlier candidate on ties.
  always_comb begin
    sel_k_s    = '0;
    sel_sad_s  = '0;
    best_dx_d  = best_dx_q;
    best_dy_d  = best_dy_q;
    best_sad_d = best_sad_q;
    for (int k = 0; k < BLK; k++) begin
      sel_k_s   = sel_k_s | ({DXW{acc_capture_q[k]}} & DXW'(k));
      sel_sad_s = sel_sad_s | ({DW{acc_capture_q[k]}} & bus.accumulate_bus[k*DW +: DW]);
    end
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        best_dx_d  = '0;
        best_dy_d  = '0;
        best_sad_d = '1;
      end else begin
        best_sad_d = best_sad_q;
      end
    end else if ((|acc_capture_q) && (sel_sad_s < best_sad_q)) begin
      best_dx_d  = sel_k_s;
      best_dy_d  = cand_dy_q;
      best_sad_d = sel_sad_s;
    end else begin
      best_sad_d = best_sad_q;
    end
  end
`endif

  // State, counters and every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      t_q           <= '0;
      v_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      r_addr_q      <= '0;
      s1_addr_q     <= '0;
      s2_addr_q     <= '0;
      mux_q         <= '0;
      new_dist_q    <= '0;
      acc_capture_q <= '0;
      cand_dy_q     <= '0;
`ifdef ME_BEST_MV_EN
      best_dx_q     <= '0;
      best_dy_q     <= '0;
      best_sad_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      v_q           <= v_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      r_addr_q      <= r_addr_d;
      s1_addr_q     <= s1_addr_d;
      s2_addr_q     <= s2_addr_d;
      mux_q         <= mux_d;
      new_dist_q    <= new_dist_d;
      acc_capture_q <= acc_capture_d;
      cand_dy_q     <= cand_dy_d;
`ifdef ME_BEST_MV_EN
      best_dx_q     <= best_dx_d;
      best_dy_q     <= best_dy_d;
      best_sad_q    <= best_sad_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.r_addr      = r_addr_q;
  assign bus.s1_addr     = s1_addr_q;
  assign bus.s2_addr     = s2_addr_q;
  assign bus.s1s2_mux    = mux_q;
  assign bus.new_dist    = new_dist_q;
  assign bus.acc_capture = acc_capture_q;
  assign bus.cand_dy     = cand_dy_q;
`ifdef ME_BEST_MV_EN
  assign bus.best_dx     = best_dx_q;
  assign bus.best_dy     = best_dy_q;
  assign bus.best_sad    = best_sad_q;
`endif
endmodule

// File: tb/tb_me_array_sequencer.sv
// Directed bench for me_array_sequencer with BLK=4, NV=2, PE_LAT=1 (20 cycles per pass).
// Best-vector checks are compiled when ME_BEST_MV_EN is defined.
`timescale 1ns/1ps
module tb_me_array_sequencer;
  localparam int BLK    = 4;
  localparam int NV     = 2;
  localparam int PE_LAT = 1;
`ifdef ME_BEST_MV_EN
  localparam int DW     = 16;
`endif

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

`ifdef ME_BEST_MV_EN
  me_array_sequencer_if #(.BLK(BLK), .DW(DW), .NV(NV)) bus ();
  me_array_sequencer #(.BLK(BLK), .NV(NV), .DW(DW), .PE_LAT(PE_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  // PE SADs per row: v=0 -> {PE3..PE0} = 8,4,3,9 ; v=1 -> 3,3,5,6. Best is PE1@v=0 (tie with PE2/PE3@v=1).
  always_comb begin
    if (bus.cand_dy == 1'b0) begin
      bus.accumulate_bus = {16'd8, 16'd4, 16'd3, 16'd9};
    end else begin
      bus.accumulate_bus = {16'd3, 16'd3, 16'd5, 16'd6};
    end
  end
`else
  me_array_sequencer_if #(.BLK(BLK), .NV(NV)) bus ();
  me_array_sequencer #(.BLK(BLK), .NV(NV), .PE_LAT(PE_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_raddr", 32'(bus.r_addr), 32'd0);
    chk("rst_mux",   32'(bus.s1s2_mux), 32'd0);
    chk("rst_nd",    32'(bus.new_dist), 32'd0);
    chk("rst_acc",   32'(bus.acc_capture), 32'd0);
    chk("rst_dy",    32'(bus.cand_dy), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Full search: start sampled at the next edge, cycle 0 follows it.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c <= 41; c++) begin
      chk("busy", 32'(bus.busy), 32'(c < 40));
      chk("done", 32'(bus.done), 32'(c == 40));
      case (c)
        0: begin
          chk("c0_nd",  32'(bus.new_dist), 32'd1);
          chk("c0_ra",  32'(bus.r_addr), 32'd0);
          chk("c0_mux", 32'(bus.s1s2_mux), 32'd15);
          chk("c0_s1",  32'(bus.s1_addr), 32'd0);
          chk("c0_s2",  32'(bus.s2_addr), 32'd0);
`ifdef ME_BEST_MV_EN
          chk("c0_bsad", 32'(bus.best_sad), 32'd65535);
`endif
        end
        1: begin
          chk("c1_nd", 32'(bus.new_dist), 32'd2);
          chk("c1_ra", 32'(bus.r_addr), 32'd1);
        end
        2: chk("c2_nd", 32'(bus.new_dist), 32'd4);
        3: begin
          chk("c3_nd",  32'(bus.new_dist), 32'd8);
          chk("c3_mux", 32'(bus.s1s2_mux), 32'd15);
        end
        4: begin
          chk("c4_nd",  32'(bus.new_dist), 32'd0);
          chk("c4_mux", 32'(bus.s1s2_mux), 32'd1);
        end
        5: begin
          chk("c5_ra",  32'(bus.r_addr), 32'd5);
          chk("c5_s1",  32'(bus.s1_addr), 32'd9);
          chk("c5_s2",  32'(bus.s2_addr), 32'd5);
          chk("c5_mux", 32'(bus.s1s2_mux), 32'd3);
        end
        15: begin
          chk("c15_ra",  32'(bus.r_addr), 32'd15);
          chk("c15_s1",  32'(bus.s1_addr), 32'd27);
          chk("c15_s2",  32'(bus.s2_addr), 32'd23);
          chk("c15_acc", 32'(bus.acc_capture), 32'd0);
        end
        16: begin
          chk("c16_ra",  32'(bus.r_addr), 32'd0);
          chk("c16_s1",  32'(bus.s1_addr), 32'd0);
          chk("c16_s2",  32'(bus.s2_addr), 32'd28);
          chk("c16_acc", 32'(bus.acc_capture), 32'd1);
        end
        19: begin
          chk("c19_acc", 32'(bus.acc_capture), 32'd8);
          chk("c19_dy",  32'(bus.cand_dy), 32'd0);
        end
        20: begin
          chk("c20_nd",  32'(bus.new_dist), 32'd1);
          chk("c20_dy",  32'(bus.cand_dy), 32'd1);
          chk("c20_s1",  32'(bus.s1_addr), 32'd8);
          chk("c20_acc", 32'(bus.acc_capture), 32'd0);
        end
        39: begin
          chk("c39_acc", 32'(bus.acc_capture), 32'd8);
          chk("c39_dy",  32'(bus.cand_dy), 32'd1);
        end
        40: begin
          chk("c40_dy",  32'(bus.cand_dy), 32'd0);
          chk("c40_mux", 32'(bus.s1s2_mux), 32'd0);
          chk("c40_acc", 32'(bus.acc_capture), 32'd0);
`ifdef ME_BEST_MV_EN
          chk("c40_bdx",  32'(bus.best_dx), 32'd1);
          chk("c40_bdy",  32'(bus.best_dy), 32'd0);
          chk("c40_bsad", 32'(bus.best_sad), 32'd3);
`endif
        end
        41: begin
`ifdef ME_BEST_MV_EN
          chk("c41_bdx",  32'(bus.best_dx), 32'd1);
          chk("c41_bsad", 32'(bus.best_sad), 32'd3);
`endif
          chk("c41_ra", 32'(bus.r_addr), 32'd0);
        end
        default: begin
        end
      endcase
      tick();
    end

    // Second search with start held high while busy, then reset at t=7 of v=1.
    bus.start = 1'b1;
    tick();
    for (int c = 0; c < 27; c++) begin
      case (c)
        1:  chk("r1_nd", 32'(bus.new_dist), 32'd2);
        5:  chk("r5_ra", 32'(bus.r_addr), 32'd5);
        20: begin
          chk("r20_nd", 32'(bus.new_dist), 32'd1);
          chk("r20_dy", 32'(bus.cand_dy), 32'd1);
        end
        25: begin
          chk("r25_s1", 32'(bus.s1_addr), 32'd17);
          chk("r25_s2", 32'(bus.s2_addr), 32'd13);
        end
        default: begin
        end
      endcase
      chk("r_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    chk("r27_ra", 32'(bus.r_addr), 32'd7);
    chk("r27_s1", 32'(bus.s1_addr), 32'd19);
    chk("r27_dy", 32'(bus.cand_dy), 32'd1);
    bus.start = 1'b0;
    reset     = 1'b1;
    tick();
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_done", 32'(bus.done), 32'd0);
    chk("ab_ra",   32'(bus.r_addr), 32'd0);
    chk("ab_s1",   32'(bus.s1_addr), 32'd0);
    chk("ab_s2",   32'(bus.s2_addr), 32'd0);
    chk("ab_mux",  32'(bus.s1s2_mux), 32'd0);
    chk("ab_nd",   32'(bus.new_dist), 32'd0);
    chk("ab_acc",  32'(bus.acc_capture), 32'd0);
    chk("ab_dy",   32'(bus.cand_dy), 32'd0);
`ifdef ME_BEST_MV_EN
    chk("ab_bsad", 32'(bus.best_sad), 32'd0);
`endif
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      chk("post_done", 32'(bus.done), 32'd0);
      chk("post_busy", 32'(bus.busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
